// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver, LSB first, idle-high line.
//
// rx is synchronised through two flops, with a third history flop used to
// detect the start-bit falling edge. A baud counter derived from CLK/BPS
// times a single mid-bit sample of the synchronised line per bit. Each good
// byte is presented as a one-cycle po_data/po_flag strobe, suitable for
// feeding uart_tx pi_data/pi_flag directly.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   rx        in   serial line (asynchronous to clk, idle high)
//   po_data   out  [7:0] last correctly framed byte, held until the next one
//   po_flag   out  one-cycle pulse when po_data is updated
//   frame_err out  one-cycle pulse when the stop bit is sampled low
//   busy      out  high while a frame is being received
module uart_rx #(
  parameter int unsigned CLK = 100_000_000,
  parameter int unsigned BPS = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned BAUD_CNT_MAX = CLK / BPS;
  localparam int unsigned HALF         = BAUD_CNT_MAX / 2;
  localparam int unsigned CW           = $clog2(BAUD_CNT_MAX) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_s1, r_s2, r_s3;
  logic [CW-1:0]   r_baud_cnt, w_baud_nxt;
  logic [3:0]      r_bit_cnt, w_bit_nxt;
  logic [7:0]      r_shreg, w_shreg_nxt;
  logic [7:0]      w_data_nxt;
  logic            w_flag_nxt, w_err_nxt, w_busy_nxt;
  logic            w_fall, w_sample;

  assign w_fall   = r_s3 & ~r_s2;
  assign w_sample = (r_baud_cnt == CW'(HALF));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= rx;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      po_data    <= '0;
      po_flag    <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shreg    <= w_shreg_nxt;
      po_data    <= w_data_nxt;
      po_flag    <= w_flag_nxt;
      frame_err  <= w_err_nxt;
      busy       <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = po_data;
    w_flag_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_busy_nxt  = busy;
    w_baud_nxt  = r_baud_cnt;
    if (busy) begin
      w_baud_nxt = (r_baud_cnt == CW'(BAUD_CNT_MAX - 1)) ? '0 : r_baud_cnt + CW'(1);
    end

    unique case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        // Only an edge starts a frame, so a line held low (break) stays idle.
        if (w_fall) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_sample) begin
          if (!r_s2) begin
            w_bit_nxt   = 4'd1;
            w_state_nxt = S_DATA;
          end else begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_sample) begin
          w_shreg_nxt = {r_s2, r_shreg[7:1]};
          w_bit_nxt   = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd8) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        // Returning mid stop bit leaves half a bit to catch a back-to-back start edge.
        if (w_sample) begin
          if (r_s2) begin
            w_data_nxt = r_shreg;
            w_flag_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx at CLK=160, BPS=10 (16 clk/bit).
module tb_uart_rx;

  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx_w;
  logic [7:0] po_data;
  logic       po_flag, frame_err, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Bench-side transmitter used for the loopback step.
  logic       tx_line = 1'b1;
  logic       pi_flag = 1'b0;
  logic [7:0] pi_data = 8'h00;
  logic [9:0] tx_sh = 10'h3FF;
  int         tx_bits = 0;
  int         tx_cnt = 0;

  always @(posedge clk) begin
    if (pi_flag) begin
      tx_sh   <= {1'b1, pi_data, 1'b0};
      tx_bits <= 10;
      tx_cnt  <= 0;
    end else if (tx_bits > 0) begin
      tx_line <= tx_sh[0];
      if (tx_cnt == BIT - 1) begin
        tx_cnt  <= 0;
        tx_sh   <= tx_sh >> 1;
        tx_bits <= tx_bits - 1;
      end else begin
        tx_cnt <= tx_cnt + 1;
      end
    end else begin
      tx_line <= 1'b1;
    end
  end

  assign rx_w = loop_en ? tx_line : rx_drv;

  uart_rx #(.CLK(160), .BPS(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx_w),
    .po_data   (po_data),
    .po_flag   (po_flag),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Output monitor: tallies pulses and records their timing and data.
  int         cyc = 0;
  int         nflag = 0;
  int         nerr = 0;
  int         nboth = 0;
  int         nlong = 0;
  int         nbusy_bad = 0;
  int         flag_cyc[$];
  logic [7:0] flag_dat[$];
  logic       prev_flag = 1'b0;
  logic       prev_err = 1'b0;
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (po_flag) begin
      nflag <= nflag + 1;
      flag_cyc.push_back(cyc);
      flag_dat.push_back(po_data);
      // busy must drop on the same edge the flag rises
      if (busy || !prev_busy) nbusy_bad <= nbusy_bad + 1;
    end
    if (frame_err) nerr <= nerr + 1;
    if (po_flag && frame_err) nboth <= nboth + 1;
    if ((po_flag && prev_flag) || (frame_err && prev_err)) nlong <= nlong + 1;
    prev_flag <= po_flag;
    prev_err  <= frame_err;
    prev_busy <= busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stopv);
    rx_drv = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      idle(BIT);
    end
    rx_drv = stopv;
    idle(BIT);
  endtask

  int f0, e0, bcnt;
  logic [7:0] b96;

  initial begin
    idle(3);
    #1;
    chk("rst_po_data", po_data, 8'h00);
    chk("rst_po_flag", po_flag, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(5);

    // Single frame
    send(8'h55, 1'b1);
    rx_drv = 1'b1;
    idle(20);
    chk("single_nflag", nflag, 1);
    chk("single_data", flag_dat[0], 8'h55);
    chk("single_po_data", po_data, 8'h55);
    chk("single_nerr", nerr, 0);
    chk("single_busy_edge", nbusy_bad, 0);

    // Back-to-back frames, no idle gap
    send(8'hA3, 1'b1);
    send(8'h0F, 1'b1);
    rx_drv = 1'b1;
    idle(20);
    chk("b2b_nflag", nflag, 3);
    chk("b2b_data1", flag_dat[1], 8'hA3);
    chk("b2b_data2", flag_dat[2], 8'h0F);
    chk("b2b_spacing", flag_cyc[2] - flag_cyc[1], 160);

    // Glitch: 4 clk low
    bcnt = 0;
    rx_drv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) rx_drv = 1'b1;
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("glitch_busy_cycles", bcnt, 9);
    chk("glitch_nflag", nflag, 3);
    chk("glitch_nerr", nerr, 0);
    chk("glitch_po_data", po_data, 8'h0F);

    // Framing error followed by a break
    send(8'h81, 1'b0);
    bcnt = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk("ferr_nerr", nerr, 1);
    chk("ferr_nflag", nflag, 3);
    chk("ferr_po_data", po_data, 8'h0F);
    chk("break_busy_cycles", bcnt, 0);
    rx_drv = 1'b1;
    idle(BIT);
    send(8'h3C, 1'b1);
    idle(20);
    chk("after_break_data", po_data, 8'h3C);
    chk("after_break_nflag", nflag, 4);

    // Reset mid-frame during data bit 4 of 0x96
    b96 = 8'h96;
    f0 = nflag;
    e0 = nerr;
    rx_drv = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      rx_drv = b96[i];
      idle(BIT);
    end
    rx_drv = b96[4];
    idle(BIT / 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_po_data", po_data, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_po_flag", po_flag, 1'b0);
    chk("midrst_frame_err", frame_err, 1'b0);
    rx_drv = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(200);
    chk("midrst_no_flag", nflag - f0, 0);
    chk("midrst_no_err", nerr - e0, 0);
    send(8'hFF, 1'b1);
    idle(20);
    chk("midrst_next_data", po_data, 8'hFF);

    // Loopback through the bench transmitter
    f0 = nflag;
    loop_en = 1'b1;
    pi_data = 8'h5A;
    pi_flag = 1'b1;
    @(negedge clk);
    pi_flag = 1'b0;
    bcnt = 0;
    while (nflag == f0 && bcnt < 400) begin
      @(negedge clk);
      bcnt++;
    end
    chk("loop_timeout", (bcnt < 400) ? 1 : 0, 1);
    idle(60);
    chk("loop_data", po_data, 8'h5A);
    chk("loop_nflag", nflag - f0, 1);

    // Global pulse properties over the whole run
    chk("pulse_overlap", nboth, 0);
    chk("pulse_width", nlong, 0);
    chk("busy_at_flag", nbusy_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
